// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request and main-memory bus bundle for mem_access_ctrl
interface mem_access_ctrl_if #(
  parameter int DATAWIDTH_BUS = 32
);
  logic                     MEM_ACCESS_CTRL_REQ_In;
  logic                     MEM_ACCESS_CTRL_WE_In;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_ADDR_InBus;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_WDATA_InBus;
  logic                     MEM_ACCESS_CTRL_ACK_In;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_Data_InBus;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_A_OutBus;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_B_OutBus;
  logic                     MEM_ACCESS_CTRL_RD_Out;
  logic                     MEM_ACCESS_CTRL_WRMain_Out;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_RDATA_OutBus;
  logic                     MEM_ACCESS_CTRL_BUSY_Out;
  logic                     MEM_ACCESS_CTRL_DONE_Out;
  logic                     MEM_ACCESS_CTRL_ERR_Out;

  // Controller side: takes requests and memory responses, drives the memory bus.
  modport master (
    input  MEM_ACCESS_CTRL_REQ_In, MEM_ACCESS_CTRL_WE_In,
    input  MEM_ACCESS_CTRL_ADDR_InBus, MEM_ACCESS_CTRL_WDATA_InBus,
    input  MEM_ACCESS_CTRL_ACK_In, MEM_ACCESS_CTRL_Data_InBus,
    output MEM_ACCESS_CTRL_A_OutBus, MEM_ACCESS_CTRL_B_OutBus,
    output MEM_ACCESS_CTRL_RD_Out, MEM_ACCESS_CTRL_WRMain_Out,
    output MEM_ACCESS_CTRL_RDATA_OutBus, MEM_ACCESS_CTRL_BUSY_Out,
    output MEM_ACCESS_CTRL_DONE_Out, MEM_ACCESS_CTRL_ERR_Out
  );

  // Environment side: control unit plus main memory.
  modport slave (
    output MEM_ACCESS_CTRL_REQ_In, MEM_ACCESS_CTRL_WE_In,
    output MEM_ACCESS_CTRL_ADDR_InBus, MEM_ACCESS_CTRL_WDATA_InBus,
    output MEM_ACCESS_CTRL_ACK_In, MEM_ACCESS_CTRL_Data_InBus,
    input  MEM_ACCESS_CTRL_A_OutBus, MEM_ACCESS_CTRL_B_OutBus,
    input  MEM_ACCESS_CTRL_RD_Out, MEM_ACCESS_CTRL_WRMain_Out,
    input  MEM_ACCESS_CTRL_RDATA_OutBus, MEM_ACCESS_CTRL_BUSY_Out,
    input  MEM_ACCESS_CTRL_DONE_Out, MEM_ACCESS_CTRL_ERR_Out
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-transfer main-memory initiator with ACK timeout
module mem_access_ctrl #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TIMEOUT_WIDTH  = 4
) (
  input  logic               MEM_ACCESS_CTRL_CLOCK_50,
  input  logic               MEM_ACCESS_CTRL_ResetInLow_In,
  mem_access_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [DATAWIDTH_BUS-1:0] ZERO_WORD = '0;
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE   = TIMEOUT_WIDTH'(1);

  state_t                   state;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;
  logic                     we_q;

  // Transfer FSM; every output is a register so nothing flows combinationally from inputs.
  always_ff @(posedge MEM_ACCESS_CTRL_CLOCK_50 or negedge MEM_ACCESS_CTRL_ResetInLow_In) begin
    if (!MEM_ACCESS_CTRL_ResetInLow_In) begin
      state                            <= S_IDLE;
      wait_cnt                         <= '0;
      we_q                             <= 1'b0;
      bus.MEM_ACCESS_CTRL_A_OutBus     <= ZERO_WORD;
      bus.MEM_ACCESS_CTRL_B_OutBus     <= ZERO_WORD;
      bus.MEM_ACCESS_CTRL_RD_Out       <= 1'b0;
      bus.MEM_ACCESS_CTRL_WRMain_Out   <= 1'b0;
      bus.MEM_ACCESS_CTRL_RDATA_OutBus <= ZERO_WORD;
      bus.MEM_ACCESS_CTRL_BUSY_Out     <= 1'b0;
      bus.MEM_ACCESS_CTRL_DONE_Out     <= 1'b0;
      bus.MEM_ACCESS_CTRL_ERR_Out      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.MEM_ACCESS_CTRL_RD_Out     <= 1'b0;
          bus.MEM_ACCESS_CTRL_WRMain_Out <= 1'b0;
          bus.MEM_ACCESS_CTRL_BUSY_Out   <= 1'b0;
          bus.MEM_ACCESS_CTRL_DONE_Out   <= 1'b0;
          bus.MEM_ACCESS_CTRL_ERR_Out    <= 1'b0;
          if (bus.MEM_ACCESS_CTRL_REQ_In) begin
            // The output address/data registers double as the request latch,
            // so they stay frozen until the next accepted request.
            bus.MEM_ACCESS_CTRL_A_OutBus   <= bus.MEM_ACCESS_CTRL_ADDR_InBus;
            bus.MEM_ACCESS_CTRL_B_OutBus   <= bus.MEM_ACCESS_CTRL_WDATA_InBus;
            we_q                           <= bus.MEM_ACCESS_CTRL_WE_In;
            wait_cnt                       <= '0;
            bus.MEM_ACCESS_CTRL_RD_Out     <= ~bus.MEM_ACCESS_CTRL_WE_In;
            bus.MEM_ACCESS_CTRL_WRMain_Out <= bus.MEM_ACCESS_CTRL_WE_In;
            bus.MEM_ACCESS_CTRL_BUSY_Out   <= 1'b1;
            state                          <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          // ACK is checked first so it wins over a timeout on the same edge.
          if (bus.MEM_ACCESS_CTRL_ACK_In) begin
            if (!we_q) begin
              bus.MEM_ACCESS_CTRL_RDATA_OutBus <= bus.MEM_ACCESS_CTRL_Data_InBus;
            end
            bus.MEM_ACCESS_CTRL_RD_Out     <= 1'b0;
            bus.MEM_ACCESS_CTRL_WRMain_Out <= 1'b0;
            bus.MEM_ACCESS_CTRL_DONE_Out   <= 1'b1;
            bus.MEM_ACCESS_CTRL_ERR_Out    <= 1'b0;
            state                          <= S_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            bus.MEM_ACCESS_CTRL_RD_Out     <= 1'b0;
            bus.MEM_ACCESS_CTRL_WRMain_Out <= 1'b0;
            bus.MEM_ACCESS_CTRL_DONE_Out   <= 1'b1;
            bus.MEM_ACCESS_CTRL_ERR_Out    <= 1'b1;
            state                          <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          bus.MEM_ACCESS_CTRL_DONE_Out <= 1'b0;
          bus.MEM_ACCESS_CTRL_ERR_Out  <= 1'b0;
          bus.MEM_ACCESS_CTRL_BUSY_Out <= 1'b0;
          state                        <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req, we, ack;
  logic [DW-1:0] addr, wdata, mdata;
  logic [DW-1:0] a_out, b_out, rdata;
  logic          rd, wr, busy, done, err;

  mem_access_ctrl_if #(.DATAWIDTH_BUS(DW)) bus ();

  assign bus.MEM_ACCESS_CTRL_REQ_In      = req;
  assign bus.MEM_ACCESS_CTRL_WE_In       = we;
  assign bus.MEM_ACCESS_CTRL_ADDR_InBus  = addr;
  assign bus.MEM_ACCESS_CTRL_WDATA_InBus = wdata;
  assign bus.MEM_ACCESS_CTRL_ACK_In      = ack;
  assign bus.MEM_ACCESS_CTRL_Data_InBus  = mdata;
  assign a_out = bus.MEM_ACCESS_CTRL_A_OutBus;
  assign b_out = bus.MEM_ACCESS_CTRL_B_OutBus;
  assign rd    = bus.MEM_ACCESS_CTRL_RD_Out;
  assign wr    = bus.MEM_ACCESS_CTRL_WRMain_Out;
  assign rdata = bus.MEM_ACCESS_CTRL_RDATA_OutBus;
  assign busy  = bus.MEM_ACCESS_CTRL_BUSY_Out;
  assign done  = bus.MEM_ACCESS_CTRL_DONE_Out;
  assign err   = bus.MEM_ACCESS_CTRL_ERR_Out;

  mem_access_ctrl #(
    .DATAWIDTH_BUS (DW),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_WIDTH (4)
  ) dut (
    .MEM_ACCESS_CTRL_CLOCK_50     (clk),
    .MEM_ACCESS_CTRL_ResetInLow_In(rst_n),
    .bus                          (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] rdata_exp = '0;

  // Main-memory contents as seen by the bench.
  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
    if (a == 32'd5) return 32'h88813FFF;
    return a * 32'h9E3779B9 + 32'h01234567;
  endfunction

  // Strobe length and error outcome for an ACK that arrives d cycles late (d<0: never).
  function automatic int exp_strobes(input int d);
    return (d < 0 || d >= TO) ? TO : d + 1;
  endfunction

  function automatic logic exp_err(input int d);
    return (d < 0 || d >= TO);
  endfunction

  // Issue one request and watch it through to the idle cycle after DONE.
  task automatic run_txn(input logic t_we, input logic [DW-1:0] t_addr, input logic [DW-1:0] t_wdata,
                         input int d, output int strobes, output int dones, output logic err_done,
                         output logic ok_bus, output logic ok_misc, output logic hung);
    strobes = 0; dones = 0; err_done = 1'b0; ok_bus = 1'b1; ok_misc = 1'b1; hung = 1'b1;
    @(negedge clk);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; ack = 1'b0;
    mdata = t_we ? $urandom : mem_word(t_addr);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      if (rd || wr) begin
        strobes++;
        if (a_out !== t_addr || b_out !== t_wdata) ok_bus = 1'b0;
        if (rd !== ~t_we || wr !== t_we) ok_bus = 1'b0;
        if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) ok_misc = 1'b0;
        ack = (d >= 0) && (strobes - 1 >= d);
      end else if (done) begin
        dones++;
        err_done = err;
        if (busy !== 1'b1) ok_misc = 1'b0;
        if (a_out !== t_addr || b_out !== t_wdata) ok_bus = 1'b0;
        ack = 1'($urandom_range(0, 1));
      end else begin
        req = 1'b0; ack = 1'b0;
        if (busy !== 1'b0 || err !== 1'b0) ok_misc = 1'b0;
        if (dones > 0) hung = 1'b0;
        else ok_misc = 1'b0;
        break;
      end
    end
    req = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; ack = 1'b1; we = 1'b0; addr = 32'd7; wdata = 32'h55; mdata = mem_word(32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({a_out, b_out, rd, wr, rdata, busy, done, err} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: rd=%b wr=%b busy=%b done=%b err=%b a=%h rdata=%h, required all zero",
                 i, rd, wr, busy, done, err, a_out, rdata);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd !== 1'b1 || a_out !== 32'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_req: rd=%b a=%h busy=%b, required rd=1 a=00000007 busy=1", rd, a_out, busy);
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_done: done=%b err=%b, required done=1 err=0", done, err);
    end
    ack = 1'b0;
    @(negedge clk);
    rdata_exp = mem_word(32'd7);
    checks++;
    if (rdata !== rdata_exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_rdata: rdata=%h busy=%b, required rdata=%h busy=0", rdata, busy, rdata_exp);
    end
  endtask

  task automatic test_read();
    int s, n; logic e, ob, om, h;
    run_txn(1'b0, 32'd5, $urandom, 0, s, n, e, ob, om, h);
    rdata_exp = 32'h88813FFF;
    checks++;
    if (h !== 1'b0 || s != 1 || n != 1 || e !== 1'b0) begin
      errors++;
      $display("FAIL read_timing: hung=%b strobes=%0d dones=%0d err=%b, required 0 1 1 0", h, s, n, e);
    end
    checks++;
    if (ob !== 1'b1 || om !== 1'b1) begin
      errors++;
      $display("FAIL read_bus: bus_ok=%b misc_ok=%b, required 1 1", ob, om);
    end
    checks++;
    if (rdata !== rdata_exp) begin
      errors++;
      $display("FAIL read_rdata: got %h, required %h", rdata, rdata_exp);
    end
  endtask

  task automatic test_write();
    int s, n; logic e, ob, om, h;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 3, s, n, e, ob, om, h);
    checks++;
    if (h !== 1'b0 || s != 4 || n != 1 || e !== 1'b0) begin
      errors++;
      $display("FAIL write_timing: hung=%b strobes=%0d dones=%0d err=%b, required 0 4 1 0", h, s, n, e);
    end
    checks++;
    if (ob !== 1'b1 || om !== 1'b1 || rdata !== rdata_exp) begin
      errors++;
      $display("FAIL write_bus: bus_ok=%b misc_ok=%b rdata=%h, required 1 1 %h", ob, om, rdata, rdata_exp);
    end
  endtask

  task automatic test_timeout();
    int s, n; logic e, ob, om, h;
    run_txn(1'b0, 32'h123, 32'h0, -1, s, n, e, ob, om, h);
    checks++;
    if (h !== 1'b0 || s != TO || n != 1 || e !== 1'b1) begin
      errors++;
      $display("FAIL timeout: hung=%b strobes=%0d dones=%0d err=%b, required 0 %0d 1 1", h, s, n, e, TO);
    end
    checks++;
    if (ob !== 1'b1 || om !== 1'b1 || rdata !== rdata_exp) begin
      errors++;
      $display("FAIL timeout_hold: bus_ok=%b misc_ok=%b rdata=%h, required 1 1 %h", ob, om, rdata, rdata_exp);
    end
  endtask

  task automatic test_back_to_back();
    int next_idx;
    logic exp_rd, exp_done;
    logic [DW-1:0] exp_a;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'd0; ack = 1'b1; next_idx = 1; mdata = mem_word(32'd0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp_rd   = (c % 3 == 1);
      exp_done = (c % 3 == 2);
      exp_a    = DW'((c - 1) / 3);
      checks++;
      if (rd !== exp_rd || done !== exp_done || (exp_rd && a_out !== exp_a)) begin
        errors++;
        $display("FAIL b2b cycle %0d: rd=%b done=%b a=%h, required rd=%b done=%b a=%h",
                 c, rd, done, a_out, exp_rd, exp_done, exp_a);
      end
      mdata = mem_word(a_out);
      if (!busy) begin
        addr = DW'(next_idx);
        next_idx++;
      end else begin
        addr = $urandom;
      end
      if (c == 8) req = 1'b0;
    end
    ack = 1'b0;
    rdata_exp = mem_word(32'd2);
    checks++;
    if (rdata !== rdata_exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rdata: rdata=%h busy=%b, required %h 0", rdata, busy, rdata_exp);
    end
  endtask

  task automatic test_async_reset();
    int s, n; logic e, ob, om, h;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h40; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 1'b0;
    end
    checks++;
    if (rd !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: rd=%b, required 1", rd);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL arst_drop: rd=%b busy=%b done=%b, required 0 0 0", rd, busy, done);
    end
    @(negedge clk);
    rdata_exp = '0;
    checks++;
    if (done !== 1'b0 || rdata !== rdata_exp || a_out !== '0) begin
      errors++;
      $display("FAIL arst_hold: done=%b rdata=%h a=%h, required 0 0 0", done, rdata, a_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL arst_idle: busy=%b rd=%b done=%b, required 0 0 0", busy, rd, done);
    end
    run_txn(1'b0, 32'h9, 32'h0, 1, s, n, e, ob, om, h);
    rdata_exp = mem_word(32'h9);
    checks++;
    if (h !== 1'b0 || s != 2 || n != 1 || e !== 1'b0 || rdata !== rdata_exp) begin
      errors++;
      $display("FAIL arst_after: hung=%b strobes=%0d dones=%0d err=%b rdata=%h, required 0 2 1 0 %h",
               h, s, n, e, rdata, rdata_exp);
    end
  endtask

  task automatic test_random();
    int s, n, d; logic e, ob, om, h, t_we;
    logic [DW-1:0] t_addr, t_wdata;
    for (int k = 0; k < 12; k++) begin
      t_we = 1'($urandom_range(0, 1));
      t_addr = $urandom; t_wdata = $urandom;
      d = int'($urandom_range(0, 19)) - 1;
      run_txn(t_we, t_addr, t_wdata, d, s, n, e, ob, om, h);
      if (!t_we && !exp_err(d)) rdata_exp = mem_word(t_addr);
      checks++;
      if (h !== 1'b0 || s != exp_strobes(d) || n != 1 || e !== exp_err(d)) begin
        errors++;
        $display("FAIL rand%0d_timing we=%b d=%0d: hung=%b strobes=%0d dones=%0d err=%b, required 0 %0d 1 %b",
                 k, t_we, d, h, s, n, e, exp_strobes(d), exp_err(d));
      end
      checks++;
      if (ob !== 1'b1 || om !== 1'b1 || rdata !== rdata_exp) begin
        errors++;
        $display("FAIL rand%0d_data: bus_ok=%b misc_ok=%b rdata=%h, required 1 1 %h", k, ob, om, rdata, rdata_exp);
      end
    end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; ack = 1'b0; addr = '0; wdata = '0; mdata = '0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
